// File: rtl/mips_sramlike_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mips_sramlike_bridge                                          |
// | Description : Bridges NCH single-cycle SRAM-style core ports onto one       |
// |               sram-like bus (req/addr_ok/data_ok). Channels are served in   |
// |               fixed priority (ch0 first); a global stall is held until all  |
// |               channels requesting in the current pipeline cycle are done.   |
// |               Optional macro BRIDGE_ADDR_MAP_EN clears the top three        |
// |               address bits for kseg0/kseg1 accesses.                        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module mips_sramlike_bridge #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             cpu_en,
  input  logic [NCH*(DATA_W/8)-1:0]  cpu_wen,
  input  logic [NCH*ADDR_W-1:0]      cpu_addr,
  input  logic [NCH*DATA_W-1:0]      cpu_wdata,
  output logic [NCH*DATA_W-1:0]      cpu_rdata,
  output logic                       cpu_stall,
  output logic                       bus_req,
  output logic                       bus_wr,
  output logic [1:0]                 bus_size,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [DATA_W-1:0]          bus_wdata,
  input  logic                       bus_addr_ok,
  input  logic                       bus_data_ok,
  input  logic [DATA_W-1:0]          bus_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [BE_W-1:0] c_byte_one = {{(BE_W-1){1'b0}}, 1'b1};
  localparam logic [BE_W-1:0] c_half_one = {{(BE_W-2){1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NCH-1:0]      r_done;
  logic [SEL_W-1:0]    r_sel;
  logic [NCH-1:0]      w_pending;
  logic                w_any;
  logic [SEL_W-1:0]    w_first;
  logic [BE_W-1:0]     w_first_wen;
  logic [1:0]          w_first_size;
  logic [ADDR_W-1:0]   w_first_addr;

  assign w_pending = cpu_en & ~r_done;
  assign w_any     = |w_pending;
  assign cpu_stall = w_any;

  // Pick the lowest-index pending channel and derive its bus fields
  always_comb begin
    w_first = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_pending[i]) w_first = SEL_W'(i);
    end
    w_first_wen = cpu_wen[w_first*BE_W +: BE_W];
    // Read, full word and irregular byte masks all go out as word accesses
    w_first_size = 2'd2;
    for (int i = 0; i < BE_W; i++) begin
      if (w_first_wen == (c_byte_one << i)) w_first_size = 2'd0;
    end
    for (int k = 0; k + 1 < BE_W; k += 2) begin
      if (w_first_wen == (c_half_one << k)) w_first_size = 2'd1;
    end
    w_first_addr = cpu_addr[w_first*ADDR_W +: ADDR_W];
`ifdef BRIDGE_ADDR_MAP_EN
    // kseg0/kseg1 are unmapped windows onto low physical memory
    if (w_first_addr[ADDR_W-1 -: 2] == 2'b10) w_first_addr[ADDR_W-1 -: 3] = 3'b000;
`else
    // Bus sees the core's address unchanged
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and bus request decode
  always_comb begin
    w_state_nxt = r_state;
    bus_req     = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_ADDR;
      S_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) w_state_nxt = S_DATA;
      end
      // A data_ok arriving together with addr_ok is not seen here
      S_DATA: if (bus_data_ok) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the selected request, track completion, capture read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= '0;
      r_done    <= '0;
      cpu_rdata <= '0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_sel     <= w_first;
        bus_wr    <= |w_first_wen;
        bus_size  <= w_first_size;
        bus_addr  <= w_first_addr;
        bus_wdata <= cpu_wdata[w_first*DATA_W +: DATA_W];
      end
      // Pipeline advances this cycle: open a fresh round of accesses
      if (!w_any && |cpu_en) r_done <= '0;
      if (r_state == S_DATA && bus_data_ok) begin
        r_done[r_sel] <= 1'b1;
        if (!bus_wr) cpu_rdata[r_sel*DATA_W +: DATA_W] <= bus_rdata;
      end
    end
  end

endmodule
`default_nettype wire
